pwm_capture: RTL
================

Name: pwm_capture

Overview:
- Measures the servo PWM waveform: high time and period, in prescaled ticks.
- Reader for the PWM generator: same waveform, opposite direction.
- Results feed back into the 12-bit data path as closed-loop actuator monitoring, with a dataf-style one-cycle valid strobe.
- Sits between the board PWM pin (or a loopback of the generator output) and the control/LED logic.

Parameters:
- WIDTH, 12: width of the pulse-width result; matches the data path.
- PER_WIDTH, 16: width of the period result.
- DIV, 50: clocks per tick; 1 us at 50 MHz.
- TIMEOUT, 25000: ticks without an expected edge before timeout_o is raised.

Ports:
- clk_i  in  1: system clock. This is the block's only clock.
- reset  in  1: asynchronous, active-low reset.
- pwm_i  in  1: asynchronous PWM input.
- width_o  out  WIDTH: last measured high time, in ticks.
- period_o  out  PER_WIDTH: last measured rising-to-rising period, in ticks.
- dataf_o  out  1: one-cycle strobe when width_o and period_o update.
- sat_o  out  1: last published width or period saturated.
- timeout_o  out  1: no valid edge within TIMEOUT ticks.

Behaviour:
- Reset (reset=0, asynchronous):
  - width_o=0, period_o=0, dataf_o=0, sat_o=0, timeout_o=0.
  - Prescaler, counters and sync flops cleared; FSM goes to SYNC_WAIT.
  - Reset mid-frame discards the partial measurement.
- Input conditioning:
  - Two-flop synchronizer, then a third flop for edge detect.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - An edge is seen 3 clk_i after the pin transition. Glitches shorter than one clk_i may be lost.
- Prescaler:
  - Counts 0..DIV-1; tick is asserted when it equals DIV-1, then it wraps.
  - Forced to 0 on every rise, so ticks are phase-aligned to the frame.
- FSM states: SYNC_WAIT, MEAS_HIGH, MEAS_LOW.
  - SYNC_WAIT: ignores levels and falls; a partial first pulse is never published.
    - rise -> MEAS_HIGH; hi_cnt=0, per_cnt=0.
  - MEAS_HIGH: each tick increments hi_cnt and per_cnt.
    - fall -> MEAS_LOW; hi_cnt frozen.
  - MEAS_LOW: each tick increments per_cnt.
    - rise -> publish, then MEAS_HIGH with counters cleared in the same cycle.
- Publish (registered, the cycle after the rise is detected):
  - width_o <= hi_cnt; period_o <= per_cnt.
  - sat_o <= (either counter saturated); timeout_o <= 0; dataf_o=1 for exactly one clk_i.
- Saturation: hi_cnt stops at 2^WIDTH-1 and per_cnt stops at 2^PER_WIDTH-1. Neither wraps.
- Timeout:
  - Condition: per_cnt reaches TIMEOUT in MEAS_HIGH or MEAS_LOW, or a timeout counter reaches TIMEOUT in SYNC_WAIT. This covers pin stuck high, stuck low, and no edges ever.
  - Action: timeout_o <= 1 (held until the next publish), FSM -> SYNC_WAIT, no dataf_o.
  - width_o and period_o hold their last values.
- Rise and timeout in the same cycle: the rise wins (publish path).
- A pulse shorter than one tick publishes width_o=0. This is legal.
- Latency, pin rising edge to dataf_o: 4 clk_i.

Decomposition:
- Shared package pwm_pkg:
  - FSM state encoding (2 bits: SYNC_WAIT=0, MEAS_HIGH=1, MEAS_LOW=2).
  - Default DIV/TIMEOUT constants, also used by the PWM generator so both ends agree on tick size.
- One sub-module: pwm_sync_edge.
  - Contents: 2-flop synchronizer, delay flop, rise/fall outputs.
  - Also reused for the dataf_i strobe input.
- Top of block: prescaler, counters, FSM, output registers.

Test Plan (clk 50 MHz, DIV=50, defaults):
- 1500 us high / 20000 us period, 3 frames -> dataf_o pulses on the 2nd and 3rd rises only. Each pulse: width_o=1500±1, period_o=20000±1, sat_o=0, one cycle wide.
- Start stimulus mid-pulse (pin already high at reset release) -> the first fall is ignored, and the first dataf_o comes at the second full rise.
- pwm_i held low after a valid frame -> timeout_o=1 after 25000±1 ticks; width_o/period_o unchanged, no dataf_o. A new 1000/20000 waveform then gives the first publish at its second rise: timeout_o=0, width_o=1000±1.
- 5000 us high / 20000 us period -> width_o=4095, sat_o=1.
- Assert reset for 3 cycles mid MEAS_LOW -> all outputs 0 immediately (asynchronous); the next publish needs two fresh rises.
- 100 ns high pulse in a 20000 us period -> width_o=0, period_o=20000±1, dataf_o pulses normally.

Source files
------------

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared PWM state encoding and default tick/timeout constants
package pwm_pkg;

    typedef enum logic [1:0] {
        SYNC_WAIT = 2'd0,
        MEAS_HIGH = 2'd1,
        MEAS_LOW  = 2'd2
    } pwm_state_t;

    // Clocks per tick (1 us at 50 MHz); the PWM generator uses the same value.
    localparam int PWM_DIV     = 50;
    // Ticks without an expected edge before the capture side gives up.
    localparam int PWM_TIMEOUT = 25000;

endpackage

// File: rtl/pwm_sync_edge.sv
// rtl/pwm_sync_edge.sv - two-flop synchronizer with delay flop and rise/fall detect
module pwm_sync_edge (
    input  logic clk_i,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic       s1;
    logic       s2;
    logic       s3;
    logic [1:0] fill;
    logic       primed;

    // Synchronize the pin; fill counts edges until s3 holds real pin data.
    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            fill <= 2'd0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
            if (fill != 2'd3) begin
                fill <= fill + 2'd1;
            end
        end
    end

    // A pin already high at reset release must not look like a rising edge.
    assign primed = (fill == 2'd3);
    assign rise   = primed & s2 & ~s3;
    assign fall   = primed & ~s2 & s3;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM high-time and period capture with saturation and timeout
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int WIDTH     = 12,
    parameter int PER_WIDTH = 16,
    parameter int DIV       = PWM_DIV,
    parameter int TIMEOUT   = PWM_TIMEOUT
) (
    input  logic                 clk_i,
    input  logic                 reset,
    input  logic                 pwm_i,
    output logic [WIDTH-1:0]     width_o,
    output logic [PER_WIDTH-1:0] period_o,
    output logic                 dataf_o,
    output logic                 sat_o,
    output logic                 timeout_o
);

    localparam int PW = $clog2(DIV + 1);

    logic                 rise;
    logic                 fall;
    logic [PW-1:0]        presc;
    logic                 tick;
    pwm_state_t           state;
    pwm_state_t           state_nx;
    logic                 start;
    logic                 publish;
    logic                 expire;
    logic [WIDTH-1:0]     hi_cnt;
    logic [PER_WIDTH-1:0] per_cnt;
    logic [WIDTH-1:0]     hi_inc;
    logic [PER_WIDTH-1:0] per_inc;
    logic                 hi_max;
    logic                 to_hit;
    logic                 pend;
    logic [WIDTH-1:0]     pend_w;
    logic [PER_WIDTH-1:0] pend_p;
    logic                 pend_sat;

    pwm_sync_edge u_sync (
        .clk_i (clk_i),
        .reset (reset),
        .din   (pwm_i),
        .rise  (rise),
        .fall  (fall)
    );

    assign tick    = (presc == PW'(DIV - 1));
    assign hi_max  = (hi_cnt == '1);
    assign hi_inc  = (tick && !hi_max) ? hi_cnt + WIDTH'(1) : hi_cnt;
    assign per_inc = (tick && per_cnt != '1) ? per_cnt + PER_WIDTH'(1) : per_cnt;
    assign to_hit  = (per_cnt == PER_WIDTH'(TIMEOUT));

    // Prescaler restarts on every rise so tick boundaries line up with the frame.
    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            presc <= '0;
        end else if (rise || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            state <= SYNC_WAIT;
        end else begin
            state <= state_nx;
        end
    end

    // Next state; a rise always takes priority over a timeout in the same cycle.
    always_comb begin
        state_nx = state;
        start    = 1'b0;
        publish  = 1'b0;
        expire   = 1'b0;
        case (state)
            SYNC_WAIT: begin
                if (rise) begin
                    state_nx = MEAS_HIGH;
                    start    = 1'b1;
                end else if (to_hit) begin
                    expire = 1'b1;
                end
            end
            MEAS_HIGH: begin
                if (rise) begin
                    start = 1'b1;
                end else if (fall) begin
                    state_nx = MEAS_LOW;
                end else if (to_hit) begin
                    state_nx = SYNC_WAIT;
                    expire   = 1'b1;
                end
            end
            MEAS_LOW: begin
                if (rise) begin
                    state_nx = MEAS_HIGH;
                    start    = 1'b1;
                    publish  = 1'b1;
                end else if (to_hit) begin
                    state_nx = SYNC_WAIT;
                    expire   = 1'b1;
                end
            end
            default: state_nx = SYNC_WAIT;
        endcase
    end

    // Tick counters; per_cnt doubles as the no-edge timer while in SYNC_WAIT.
    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            hi_cnt  <= '0;
            per_cnt <= '0;
        end else if (start || expire) begin
            hi_cnt  <= '0;
            per_cnt <= '0;
        end else begin
            case (state)
                MEAS_HIGH: begin
                    hi_cnt  <= hi_inc;
                    per_cnt <= per_inc;
                end
                default: per_cnt <= per_inc;
            endcase
        end
    end

    // Snapshot the finished frame on the rise; the tick landing on that edge counts.
    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            pend     <= 1'b0;
            pend_w   <= '0;
            pend_p   <= '0;
            pend_sat <= 1'b0;
        end else begin
            pend <= publish;
            if (publish) begin
                pend_w   <= hi_cnt;
                pend_p   <= per_inc;
                pend_sat <= hi_max | (per_inc == '1);
            end
        end
    end

    // Result registers and status flags; dataf_o is high for a single clock.
    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            width_o   <= '0;
            period_o  <= '0;
            dataf_o   <= 1'b0;
            sat_o     <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            dataf_o <= pend;
            if (pend) begin
                width_o   <= pend_w;
                period_o  <= pend_p;
                sat_o     <= pend_sat;
                timeout_o <= 1'b0;
            end else if (expire) begin
                timeout_o <= 1'b1;
            end
        end
    end

endmodule
